// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between fetch and main instruction memory.
// Hits are served combinationally in the same cycle. A miss stalls fetch through busywait
// while one 128-bit line is fetched (MEM_READ) and then written into the array (UPDATE).
//
// Handshake: read_en is the request valid. The request is accepted in the cycle where
// busywait=0, and instruction is meaningful only in that cycle. On the memory side,
// mem_read is held until a cycle in which mem_busywait=0, and mem_readdata is taken in
// that same cycle.
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read_en,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;

  // Line storage: only valid bits are reset; tag/data are don't-care until filled.
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];

  // Block address of the line being refilled, and the block captured from memory.
  logic [27:0]  req_blk;
  logic [127:0] fill_data;

  logic [INDEX_BITS-1:0] cur_index;
  logic [TAG_BITS-1:0]   cur_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          cur_line;
  logic [31:0]           cur_word;
  logic                  hit;
  logic                  miss_accept;

  // The byte offset within a word is meaningless for a word-aligned fetch.
  logic unused_byte_offset;
  assign unused_byte_offset = ^address[1:0];

  assign cur_index  = address[3+INDEX_BITS:4];
  assign cur_tag    = address[31:4+INDEX_BITS];
  assign fill_index = req_blk[INDEX_BITS-1:0];
  assign fill_tag   = req_blk[27:INDEX_BITS];
  assign cur_line   = data_mem[cur_index];
  assign hit        = valid[cur_index] && (tag_mem[cur_index] == cur_tag);
  assign miss_accept = (state == IDLE) && read_en && !hit;

  // Word select within the addressed line.
  always_comb begin
    cur_word = cur_line[31:0];
    case (address[3:2])
      2'd0: cur_word = cur_line[31:0];
      2'd1: cur_word = cur_line[63:32];
      2'd2: cur_word = cur_line[95:64];
      2'd3: cur_word = cur_line[127:96];
      default: cur_word = cur_line[31:0];
    endcase
  end

  // Next-state logic: a miss goes to MEM_READ, memory completion to UPDATE, then back.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (read_en && !hit) next_state = MEM_READ;
      MEM_READ: if (!mem_busywait)   next_state = UPDATE;
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; hits in IDLE are answered without waiting for an edge.
  always_comb begin
    instruction = 32'd0;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = 28'd0;
    case (state)
      IDLE: begin
        if (read_en) begin
          busywait = !hit;
          if (hit) instruction = cur_word;
        end
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = req_blk;
      end
      UPDATE: begin
        busywait = 1'b1;
      end
      default: begin
        busywait = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any refill in flight.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Latch the missing block address once, so a later PC change cannot redirect the refill.
  always_ff @(posedge CLK) begin
    if (RESET)            req_blk <= 28'd0;
    else if (miss_accept) req_blk <= address[31:4];
  end

  // Capture the block in the cycle memory reports it ready.
  always_ff @(posedge CLK) begin
    if (RESET)                                   fill_data <= 128'd0;
    else if (state == MEM_READ && !mem_busywait) fill_data <= mem_readdata;
  end

  // Valid bits: cleared by reset, set when a line is written.
  always_ff @(posedge CLK) begin
    if (RESET)                 valid <= '0;
    else if (state == UPDATE)  valid[fill_index] <= 1'b1;
  end

  // Tag/data write on UPDATE; an existing line at the same index is simply overwritten.
  always_ff @(posedge CLK) begin
    if (!RESET && state == UPDATE) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_data;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios plus a random access phase, checked
// against a line-level model (block address held per index) and a synthetic main memory.
module tb_instruction_cache;

  localparam int INDEX_BITS = 3;
  localparam int LINES      = 1 << INDEX_BITS;

  logic         CLK;
  logic         RESET;
  logic         read_en;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_cmp;
  int n_err;

  // Reference model: which block each index holds.
  bit          m_valid [LINES];
  logic [27:0] m_blk   [LINES];

  instruction_cache #(.INDEX_BITS(INDEX_BITS)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read_en      (read_en),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synthetic main memory: word w of block b = b*256 + w*0x11 (block 0 gives 0x00,0x11,0x22,0x33).
  function automatic logic [31:0] mem_word(input logic [27:0] b, input logic [1:0] w);
    logic [31:0] bb;
    bb = {4'd0, b};
    return (bb * 32'd256) + ({30'd0, w} * 32'h11);
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    return {mem_word(b, 2'd3), mem_word(b, 2'd2), mem_word(b, 2'd1), mem_word(b, 2'd0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One IDLE cycle with no request.
  task automatic idle_cycle();
    @(negedge CLK);
    read_en = 1'b0;
    address = $urandom;
    #1;
    check("idle_busywait", {31'd0, busywait}, 32'd0);
    check("idle_instr", instruction, 32'd0);
    check("idle_mem_read", {31'd0, mem_read}, 32'd0);
  endtask

  // One fetch starting in IDLE. On a miss, memory answers after lat busy cycles.
  // redir_en changes the PC in the first MEM_READ cycle; drop_en lowers read_en there.
  task automatic access(input logic [31:0] a, input int lat,
                        input bit redir_en, input logic [31:0] redir, input bit drop_en);
    logic [27:0] blk;
    int          idx;
    bit          hit;
    int          bw;
    @(negedge CLK);
    read_en      = 1'b1;
    address      = a;
    mem_busywait = 1'b1;
    mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    blk = a[31:4];
    idx = int'(blk) % LINES;
    hit = m_valid[idx] && (m_blk[idx] == blk);
    check("lookup_busywait", {31'd0, busywait}, {31'd0, !hit});
    check("lookup_mem_read", {31'd0, mem_read}, 32'd0);
    if (hit) begin
      check("hit_instr", instruction, mem_word(blk, a[3:2]));
      return;
    end
    check("miss_instr", instruction, 32'd0);
    bw = busywait ? 1 : 0;
    @(posedge CLK);
    for (int c = 0; c <= lat; c++) begin
      @(negedge CLK);
      if (redir_en && c == 0) address = redir;
      if (drop_en && c == 0)  read_en = 1'b0;
      mem_busywait = (c < lat);
      mem_readdata = (c < lat) ? {$urandom, $urandom, $urandom, $urandom} : mem_block(blk);
      #1;
      check("mr_mem_read", {31'd0, mem_read}, 32'd1);
      check("mr_mem_address", {4'd0, mem_address}, {4'd0, blk});
      check("mr_instr", instruction, 32'd0);
      bw += busywait ? 1 : 0;
      @(posedge CLK);
    end
    @(negedge CLK);
    mem_busywait = 1'b1;
    mem_readdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("upd_mem_read", {31'd0, mem_read}, 32'd0);
    check("upd_instr", instruction, 32'd0);
    bw += busywait ? 1 : 0;
    check("miss_busy_cycles", bw, lat + 3);
    m_valid[idx] = 1'b1;
    m_blk[idx]   = blk;
    @(posedge CLK);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    RESET        = 1'b1;
    read_en      = 1'b0;
    address      = 32'd0;
    mem_readdata = 128'd0;
    mem_busywait = 1'b1;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_blk[i]   = 28'd0;
    end

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", {4'd0, mem_address}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    RESET = 1'b0;

    // Cold miss on 0x0 with a slow memory, then word0 hit and zero-latency hits on 0x4..0xC
    access(32'h0, 4, 1'b0, 32'h0, 1'b0);
    access(32'h0, 0, 1'b0, 32'h0, 1'b0);
    access(32'h4, 0, 1'b0, 32'h0, 1'b0);
    access(32'h8, 0, 1'b0, 32'h0, 1'b0);
    access(32'hC, 0, 1'b0, 32'h0, 1'b0);

    // Conflict on index 0: 0x80 evicts 0x0, which then misses again
    access(32'h80, 1, 1'b0, 32'h0, 1'b0);
    access(32'h0,  1, 1'b0, 32'h0, 1'b0);

    // Redirect during refill: 0x100 completes, then 0x200 misses on its own
    access(32'h100, 2, 1'b1, 32'h200, 1'b0);
    access(32'h200, 1, 1'b0, 32'h0, 1'b0);

    // read_en dropped mid-refill: the line still lands and hits afterwards
    access(32'h154, 2, 1'b0, 32'h0, 1'b1);
    idle_cycle();
    access(32'h158, 0, 1'b0, 32'h0, 1'b0);

    // Reset during MEM_READ aborts the refill and clears all lines
    access(32'h0, 0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    read_en = 1'b1;
    address = 32'h30;
    #1;
    check("abort_miss", {31'd0, busywait}, 32'd1);
    @(negedge CLK);
    mem_busywait = 1'b1;
    #1;
    check("abort_mr", {31'd0, mem_read}, 32'd1);
    RESET   = 1'b1;
    read_en = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("abort_mem_read", {31'd0, mem_read}, 32'd0);
    check("abort_busywait", {31'd0, busywait}, 32'd0);
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    access(32'h0,  1, 1'b0, 32'h0, 1'b0);
    access(32'h30, 0, 1'b0, 32'h0, 1'b0);

    // Fastest miss: 3 busy cycles, then a hit
    access(32'h64, 0, 1'b0, 32'h0, 1'b0);
    access(32'h64, 0, 1'b0, 32'h0, 1'b0);

    // Random traffic over a few tags per index so hits, misses and conflicts all occur
    for (int n = 0; n < 120; n++) begin
      logic [31:0] ra;
      ra = {$urandom_range(0, 3), 7'd0} | {$urandom_range(0, 7), 4'd0} | {$urandom_range(0, 3), 2'd0};
      if ($urandom_range(0, 7) == 0) idle_cycle();
      access(ra, $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom,
             $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
